// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger/capture path.
package scope_pkg;

  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned DEF_DEPTH = 256;
  localparam int unsigned DEF_PRE   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } cap_state_e;

  // Level crossing between two consecutive samples in the selected direction.
  function automatic logic trig_hit(input logic [SAMPLE_W-1:0] prev,
                                    input logic [SAMPLE_W-1:0] cur,
                                    input logic [SAMPLE_W-1:0] level,
                                    input logic                falling);
    if (falling) return (prev > level) && (cur <= level);
    else         return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
module sample_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture for the scope display.
// Define AUTO_TRIG_EN to auto-trigger after AUTO_TIMEOUT armed samples.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned PRE          = DEF_PRE,
  parameter int unsigned AUTO_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SAMPLE_W-1:0]      sample_data,
  input  logic                     sample_valid,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic                     trig_falling,
  input  logic                     arm,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     busy,
  output logic                     capture_done,
  output logic                     trig_auto
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned POST_N = DEPTH - PRE - 1;

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       trig_ptr_q, trig_ptr_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_c;
  logic                hit_c;
  logic                force_c;
  logic [AW-1:0]       rd_phys_c;

`ifdef AUTO_TRIG_EN
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          auto_q, auto_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef AUTO_TRIG_EN
      tmo_q      <= '0;
      auto_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      trig_ptr_q <= trig_ptr_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef AUTO_TRIG_EN
      tmo_q      <= tmo_d;
      auto_q     <= auto_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    trig_ptr_d = trig_ptr_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    done_d     = done_q;
    hit_c      = 1'b0;
    force_c    = 1'b0;
`ifdef AUTO_TRIG_EN
    tmo_d      = tmo_q;
    auto_d     = auto_q;
`endif

    // Every valid sample is stored while a capture runs; pointer wraps mod DEPTH.
    we_c = sample_valid && (state_q inside {ST_PREFILL, ST_ARMED, ST_POST});
    if (we_c) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      prev_d     = sample_data;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          wr_ptr_d   = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          prev_vld_d = 1'b0;
`ifdef AUTO_TRIG_EN
          tmo_d      = '0;
          auto_d     = 1'b0;
`endif
          state_d    = (PRE == 0) ? ST_ARMED : ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if (sample_valid) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == AW'(PRE - 1)) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (sample_valid) begin
          hit_c = prev_vld_q && trig_hit(prev_q, sample_data, trig_level, trig_falling);
`ifdef AUTO_TRIG_EN
          tmo_d = tmo_q + TW'(1);
          if (!hit_c && (tmo_q == TW'(AUTO_TIMEOUT - 1))) begin
            force_c = 1'b1;
            auto_d  = 1'b1;
          end
`endif
          if (hit_c || force_c) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d      = '0;
            if (POST_N == 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end
      ST_POST: begin
        if (sample_valid) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == AW'(POST_N - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = state_d inside {ST_PREFILL, ST_ARMED, ST_POST};
  end

  // Read index 0 is the oldest sample, PRE places before the trigger sample.
  assign rd_phys_c = trig_ptr_q - AW'(PRE) + rd_addr;

  sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_c),
    .waddr (wr_ptr_q),
    .wdata (sample_data),
    .raddr (rd_phys_c),
    .rdata (rd_data)
  );

  assign busy         = busy_q;
  assign capture_done = done_q;
`ifdef AUTO_TRIG_EN
  assign trig_auto    = auto_q;
`else
  assign trig_auto    = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: PRE=64 instance plus a PRE=0 instance.
module tb_trigger_capture;

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_AUTO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic [11:0] trig_level;
  logic        trig_falling;
  logic        arm, arm0;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data, rd_data0;
  logic        busy, busy0, done, done0, tauto, tauto0;

  always #5 clk = ~clk;

  trigger_capture #(.DEPTH(256), .PRE(64), .AUTO_TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_falling(trig_falling), .arm(arm), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .capture_done(done), .trig_auto(tauto));

  trigger_capture #(.DEPTH(256), .PRE(0), .AUTO_TIMEOUT(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_falling(trig_falling), .arm(arm0), .rd_addr(rd_addr),
    .rd_data(rd_data0), .busy(busy0), .capture_done(done0), .trig_auto(tauto0));

  typedef struct {
    int    kind;
    int    sel;
    int    exp;
    string tag;
  } exp_t;

  exp_t sb[$];
  logic req  = 1'b0;
  logic pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // A request becomes visible to the monitor one clock later (read latency).
  always @(posedge clk) pend <= req;

  function automatic int actual(input int kind, input int sel);
    case (kind)
      K_RD:    return (sel == 0) ? int'(rd_data) : int'(rd_data0);
      K_BUSY:  return (sel == 0) ? int'(busy)    : int'(busy0);
      K_DONE:  return (sel == 0) ? int'(done)    : int'(done0);
      default: return (sel == 0) ? int'(tauto)   : int'(tauto0);
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      if (pend) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: output presented with no expected entry");
        end else begin
          e   = sb.pop_front();
          act = actual(e.kind, e.sel);
          if (act != e.exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", e.tag, act, e.exp);
          end
        end
      end
    end
  end

  task automatic chk(input int kind, input int sel, input int exp, input string tag);
    @(negedge clk);
    sb.push_back('{kind, sel, exp, tag});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic rd(input int sel, input int addr, input int exp, input string tag);
    @(negedge clk);
    rd_addr = 8'(addr);
    sb.push_back('{K_RD, sel, exp, tag});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_arm(input int sel, input int kind, input int exp, input string tag);
    @(negedge clk);
    if (sel == 0) arm = 1'b1; else arm0 = 1'b1;
    sb.push_back('{kind, sel, exp, tag});
    req = 1'b1;
    @(negedge clk);
    arm  = 1'b0;
    arm0 = 1'b0;
    req  = 1'b0;
  endtask

  // Reset asserted just after a clock edge: checked before any further edge.
  task automatic chk_reset(input int kind, input int exp, input string tag);
    @(negedge clk);
    sb.push_back('{kind, 0, exp, tag});
    req = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic send(input int val);
    @(negedge clk);
    sample_data  = 12'(val);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_gap(input int val);
    @(negedge clk);
    sample_data  = 12'(val);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (48) @(negedge clk);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n        = 1'b0;
    sample_data  = '0;
    sample_valid = 1'b0;
    trig_level   = 12'd2048;
    trig_falling = 1'b0;
    arm          = 1'b0;
    arm0         = 1'b0;
    rd_addr      = '0;

    // Reset values, observed while reset is held.
    chk(K_RD,   0, 0, "rst_rd_data");
    chk(K_RD,   1, 0, "rst_rd_data0");
    chk(K_BUSY, 0, 0, "rst_busy");
    chk(K_DONE, 0, 0, "rst_done");
    chk(K_AUTO, 0, 0, "rst_auto");
    @(negedge clk);
    rst_n = 1'b1;

    // Rising ramp: trigger on 2048 (sample 128), done after sample 319.
    chk_arm(0, K_BUSY, 1, "up_arm_busy");
    for (int i = 0; i < 319; i++) send(i * 16);
    chk(K_DONE, 0, 0, "up_done_before_last");
    chk(K_BUSY, 0, 1, "up_busy_before_last");
    send((319 * 16) % 4096);
    chk(K_DONE, 0, 1, "up_done");
    chk(K_BUSY, 0, 0, "up_busy_after");
    chk(K_AUTO, 0, 0, "up_auto");
    rd(0, 64,  2048, "up_rd64");
    rd(0, 0,   1024, "up_rd0");
    rd(0, 63,  2032, "up_rd63");
    rd(0, 255, 1008, "up_rd255");

    // Falling ramp with an arm pulse in POST that must be ignored.
    trig_falling = 1'b1;
    chk_arm(0, K_DONE, 0, "dn_arm_clears_done");
    for (int i = 0; i < 318; i++) begin
      send((4080 - 16 * i) & 12'hFFF);
      if (i == 200) chk_arm(0, K_BUSY, 1, "dn_arm_mid_post_busy");
    end
    chk(K_DONE, 0, 0, "dn_done_before_last");
    send((4080 - 16 * 318) & 12'hFFF);
    chk(K_DONE, 0, 1, "dn_done");
    chk(K_AUTO, 0, 0, "dn_auto");
    rd(0, 64,  2048, "dn_rd64");
    rd(0, 0,   3072, "dn_rd0");
    rd(0, 254, 3104, "dn_rd254");
    rd(0, 255, 3088, "dn_rd255");

    // Arm in DONE drops capture_done on the next cycle.
    trig_falling = 1'b0;
    chk_arm(0, K_DONE, 0, "arm_in_done_drops");

    // Flat 3000 from the first sample: never a real trigger.
    for (int i = 0; i < 1087; i++) send(3000);
    chk(K_BUSY, 0, 1, "flat_busy");
    chk(K_AUTO, 0, 0, "flat_auto_early");
    send(3000);
`ifdef AUTO_TRIG_EN
    chk(K_AUTO, 0, 1, "flat_auto_set");
    chk(K_BUSY, 0, 1, "flat_busy_post");
    for (int i = 0; i < 191; i++) send(3000);
    chk(K_DONE, 0, 1, "flat_auto_done");
    rd(0, 64, 3000, "flat_rd64");
`else
    chk(K_AUTO, 0, 0, "flat_auto_tied");
    for (int i = 0; i < 200; i++) send(3000);
    chk(K_BUSY, 0, 1, "flat_busy_waits");
    chk(K_DONE, 0, 0, "flat_not_done");
`endif

    // Reach ARMED (re-armed or arm ignored depending on build), then reset.
    chk_arm(0, K_BUSY, 1, "pre_reset_busy");
    for (int i = 0; i < 70; i++) send(3000);
    chk(K_BUSY, 0, 1, "armed_busy");
    chk_reset(K_BUSY, 0, "rst_async_busy");
    chk(K_DONE, 0, 0, "rst_async_done");
    chk(K_AUTO, 0, 0, "rst_async_auto");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal capture after reset.
    chk_arm(0, K_BUSY, 1, "post_rst_arm_busy");
    for (int i = 0; i < 320; i++) send((i * 16) % 4096);
    chk(K_DONE, 0, 1, "post_rst_done");
    rd(0, 64, 2048, "post_rst_rd64");
    rd(0, 0,  1024, "post_rst_rd0");

    // PRE=0 with sparse strobes: trigger at index 0, exactly 256 samples.
    chk_arm(1, K_BUSY, 1, "p0_arm_busy");
    for (int i = 0; i < 383; i++) send_gap((i * 16) % 4096);
    chk(K_DONE, 1, 0, "p0_done_before_last");
    send_gap((383 * 16) % 4096);
    chk(K_DONE, 1, 1, "p0_done");
    rd(1, 0,   2048, "p0_rd0");
    rd(1, 1,   2064, "p0_rd1");
    rd(1, 255, 2032, "p0_rd255");

    // PRE=0: first sample above level after arm must not trigger.
    chk_arm(1, K_DONE, 0, "p0_rearm_done");
    for (int i = 0; i < 256; i++) send(3000);
    chk(K_BUSY, 1, 1, "p0_first_no_trig_busy");
    chk(K_DONE, 1, 0, "p0_first_no_trig_done");

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
